// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared constants and address classes for the data memory responder
package data_memory_pkg;

    localparam logic [3:0] MMIO_COUNTER  = 4'd0;
    localparam logic [3:0] MMIO_SCRATCH  = 4'd4;
    localparam logic [3:0] MMIO_HALT     = 4'd8;
    localparam logic [3:0] MMIO_RESERVED = 4'd12;

    typedef enum logic [2:0] {
        ACCESS_NONE,
        ACCESS_RAM,
        ACCESS_MMIO,
        ACCESS_MISALIGNED,
        ACCESS_UNMAPPED
    } access_t;

endpackage

// File: rtl/data_memory_array.sv
// rtl/data_memory_array.sv - word storage with one synchronous write port and one combinational read port
module data_memory_array #(
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_index,
    input  logic [31:0]              write_data,
    input  logic [ADDRESS_WIDTH-1:0] read_index,
    output logic [31:0]              read_data
);

    // Contents deliberately survive reset so a program image stays loaded.
    logic [31:0] mem [2**ADDRESS_WIDTH];

    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[write_index] <= write_data;
        end
    end

    assign read_data = mem[read_index];

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - data-side bus responder: RAM, MMIO registers, fault flag (DATA_MEMORY_BOUNDS_CHECK_EN)
module data_memory_responder
    import data_memory_pkg::*;
#(
    parameter int          ADDRESS_WIDTH = 10,
    parameter logic [31:0] RAM_BASE      = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE     = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        halt,
    output logic        fault
);

    localparam logic [31:0] RAM_BYTES = 32'(4 * (2**ADDRESS_WIDTH));

    logic [31:0]              ram_offset;
    logic [31:0]              mmio_offset;
    logic                     in_ram;
    logic                     in_mmio;
    logic [3:0]               mmio_reg;
    logic [ADDRESS_WIDTH-1:0] ram_index;
    logic [31:0]              ram_rdata;
    logic                     ram_we;
    access_t                  access;

    logic [31:0] cycle_count;
    logic [31:0] scratch;

    // Unsigned offsets make both window checks a single compare, wrap included.
    assign ram_offset  = data_address - RAM_BASE;
    assign mmio_offset = data_address - MMIO_BASE;
    assign in_ram      = ram_offset < RAM_BYTES;
    assign in_mmio     = mmio_offset < 32'd16;
    assign mmio_reg    = mmio_offset[3:0];
    assign ram_index   = data_address[ADDRESS_WIDTH+1:2];

    always_comb begin
        access = ACCESS_NONE;
        if (data_read || data_write) begin
            if (data_address[1:0] != 2'b00) begin
                access = ACCESS_MISALIGNED;
            end else if (in_mmio) begin
                access = ACCESS_MMIO;
            end else if (in_ram) begin
                access = ACCESS_RAM;
            end else begin
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
                access = ACCESS_UNMAPPED;
`else
                access = ACCESS_RAM;
`endif
            end
        end
    end

    // Gating with reset drops a write whose edge lands while reset is held.
    assign ram_we = reset && clk_enable && data_write && (access == ACCESS_RAM);

    data_memory_array #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_array (
        .clk         (clk),
        .write_enable(ram_we),
        .write_index (ram_index),
        .write_data  (data_writedata),
        .read_index  (ram_index),
        .read_data   (ram_rdata)
    );

    always_comb begin
        data_readdata = 32'h0;
        if (data_read) begin
            case (access)
                ACCESS_RAM: data_readdata = ram_rdata;
                ACCESS_MMIO: begin
                    case (mmio_reg)
                        MMIO_COUNTER:  data_readdata = cycle_count;
                        MMIO_SCRATCH:  data_readdata = scratch;
                        MMIO_HALT:     data_readdata = {31'b0, halt};
                        MMIO_RESERVED: data_readdata = 32'h0;
                        default:       data_readdata = 32'h0;
                    endcase
                end
                default: data_readdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= 32'h0;
            scratch     <= 32'h0;
            halt        <= 1'b0;
            fault       <= 1'b0;
        end else if (clk_enable) begin
            cycle_count <= cycle_count + 32'd1;
            if (access == ACCESS_MMIO && data_write) begin
                if (mmio_reg == MMIO_SCRATCH) begin
                    scratch <= data_writedata;
                end
                if (mmio_reg == MMIO_HALT && data_writedata[0]) begin
                    halt <= 1'b1;
                end
            end
            if (access == ACCESS_MISALIGNED || access == ACCESS_UNMAPPED) begin
                fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - randomized self-checking bench for data_memory_responder
module tb_data_memory_responder;

    localparam int          AW        = 10;
    localparam int          WORDS     = 1 << AW;
    localparam logic [31:0] MMIO_BASE = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b0;
    logic [31:0] data_address = 32'h0;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_writedata = 32'h0;
    logic [31:0] data_readdata;
    logic        halt;
    logic        fault;

    int n_compared = 0;
    int n_mismatched = 0;

    logic [31:0] ram_m [WORDS];
    logic [31:0] cnt_m;
    logic [31:0] scratch_m;
    logic        halt_m;
    logic        fault_m;

    data_memory_responder #(
        .ADDRESS_WIDTH(AW),
        .RAM_BASE     (32'h0000_0000),
        .MMIO_BASE    (MMIO_BASE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clk_enable    (clk_enable),
        .data_address  (data_address),
        .data_read     (data_read),
        .data_write    (data_write),
        .data_writedata(data_writedata),
        .data_readdata (data_readdata),
        .halt          (halt),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_mmio(input logic [31:0] a);
        return a >= MMIO_BASE;
    endfunction

    function automatic bit is_unmapped(input logic [31:0] a);
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
        return !is_mmio(a) && (a >= 32'(4 * WORDS));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a % 4 != 0) return 32'h0;
        if (is_mmio(a)) begin
            case ((a - MMIO_BASE) / 4)
                0: return cnt_m;
                1: return scratch_m;
                2: return {31'b0, halt_m};
                default: return 32'h0;
            endcase
        end
        if (is_unmapped(a)) return 32'h0;
        return ram_m[(a / 4) % WORDS];
    endfunction

    task automatic model_step(input logic [31:0] a, input bit rd, input bit wr,
                              input logic [31:0] wd, input bit en);
        if (!en) return;
        cnt_m = cnt_m + 1;
        if (!(rd || wr)) return;
        if (a % 4 != 0 || is_unmapped(a)) begin
            fault_m = 1'b1;
        end else if (is_mmio(a)) begin
            if (wr && (a - MMIO_BASE) == 4) scratch_m = wd;
            if (wr && (a - MMIO_BASE) == 8 && wd[0]) halt_m = 1'b1;
        end else if (wr) begin
            ram_m[(a / 4) % WORDS] = wd;
        end
    endtask

    task automatic model_reset();
        cnt_m = 0;
        scratch_m = 0;
        halt_m = 0;
        fault_m = 0;
    endtask

    // Drive in the low phase, check combinational outputs, then advance the model past the edge.
    task automatic do_cycle(input string tag, input logic [31:0] a, input bit rd, input bit wr,
                            input logic [31:0] wd, input bit en);
        @(negedge clk);
        data_address = a;
        data_read = rd;
        data_write = wr;
        data_writedata = wd;
        clk_enable = en;
        #1;
        check_eq({tag, "_rdata"}, data_readdata, rd ? model_read(a) : 32'h0);
        check_eq({tag, "_halt"}, {31'b0, halt}, {31'b0, halt_m});
        check_eq({tag, "_fault"}, {31'b0, fault}, {31'b0, fault_m});
        model_step(a, rd, wr, wd, en);
    endtask

    task automatic release_reset();
        @(negedge clk);
        data_read = 0;
        data_write = 0;
        clk_enable = 0;
        reset = 1;
        model_reset();
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] old40;
        logic [31:0] old80;
        int          kind;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_halt", {31'b0, halt}, 32'h0);
        check_eq("reset_fault", {31'b0, fault}, 32'h0);
        check_eq("reset_rdata", data_readdata, 32'h0);
        release_reset();

        // Counter: five edges with one disabled leaves 4.
        do_cycle("cnt0", MMIO_BASE, 1, 0, 0, 1);
        do_cycle("cnt1", MMIO_BASE, 1, 0, 0, 0);
        do_cycle("cnt2", MMIO_BASE, 1, 0, 0, 1);
        do_cycle("cnt3", MMIO_BASE, 1, 0, 0, 1);
        do_cycle("cnt4", MMIO_BASE, 1, 0, 0, 1);
        do_cycle("cnt5", MMIO_BASE, 1, 0, 0, 1);
        check_eq("cnt_after_5_edges", data_readdata, 32'd4);

        for (int i = 0; i < WORDS; i++) begin
            do_cycle("fill", 32'(i * 4), 0, 1, $urandom, 1);
        end

        do_cycle("rw_same", 32'h40, 1, 1, 32'hDEAD_BEEF, 1);
        do_cycle("rd_after", 32'h40, 1, 0, 0, 1);
        check_eq("deadbeef", data_readdata, 32'hDEAD_BEEF);

        do_cycle("wr_1000", 32'h1000, 0, 1, 32'h1234, 1);
        do_cycle("rd_0", 32'h0, 1, 0, 0, 1);
`ifndef DATA_MEMORY_BOUNDS_CHECK_EN
        check_eq("alias_word0", data_readdata, 32'h1234);
`endif

        do_cycle("scr_wr", MMIO_BASE + 4, 0, 1, 32'hA5A5_0001, 1);
        do_cycle("scr_rd", MMIO_BASE + 4, 1, 0, 0, 1);
        do_cycle("cnt_wr", MMIO_BASE, 0, 1, 32'h0BAD, 1);
        do_cycle("rsv_wr", MMIO_BASE + 12, 0, 1, 32'hFFFF_FFFF, 1);
        do_cycle("rsv_rd", MMIO_BASE + 12, 1, 0, 0, 1);
        do_cycle("halt_w1", MMIO_BASE + 8, 0, 1, 32'h1, 1);
        do_cycle("halt_rd", MMIO_BASE + 8, 1, 0, 0, 1);
        check_eq("halt_set", {31'b0, halt}, 32'h1);
        do_cycle("halt_w0", MMIO_BASE + 8, 0, 1, 32'h0, 1);
        do_cycle("halt_hold", MMIO_BASE + 8, 1, 0, 0, 1);

        old40 = ram_m[16];
        do_cycle("mis_rd", 32'h41, 1, 0, 0, 1);
        do_cycle("mis_wr", 32'h42, 0, 1, 32'h5555_5555, 1);
        do_cycle("mis_chk", 32'h40, 1, 0, 0, 1);
        check_eq("mis_word40", data_readdata, old40);
        check_eq("mis_fault", {31'b0, fault}, 32'h1);
        do_cycle("dis_wr", 32'h44, 0, 1, 32'h7777_7777, 0);
        do_cycle("dis_rd", 32'h44, 1, 0, 0, 1);

        // Reset lands in the low phase of a cycle carrying a write to 0x80.
        old80 = ram_m[32];
        @(negedge clk);
        data_address = 32'h80;
        data_read = 0;
        data_write = 1;
        data_writedata = 32'hCAFE_F00D;
        clk_enable = 1;
        #1;
        reset = 0;
        model_reset();
        #1;
        check_eq("rst_async_halt", {31'b0, halt}, 32'h0);
        check_eq("rst_async_fault", {31'b0, fault}, 32'h0);
        release_reset();
        do_cycle("rst_cnt", MMIO_BASE, 1, 0, 0, 1);
        do_cycle("rst_scr", MMIO_BASE + 4, 1, 0, 0, 1);
        do_cycle("rst_80", 32'h80, 1, 0, 0, 1);
        check_eq("rst_keep80", data_readdata, old80);

        for (int i = 0; i < 3000; i++) begin
            kind = int'($urandom_range(0, 4));
            case (kind)
                0, 4: a = {20'h0, 10'($urandom_range(0, WORDS - 1)), 2'b00};
                1: a = MMIO_BASE + 32'(4 * $urandom_range(0, 3));
                2: a = {$urandom, 2'b00} | 32'($urandom_range(1, 3));
                default: begin
                    a = $urandom & 32'hFFFF_FFFC;
                    if (a >= MMIO_BASE) a = a - 32'h1_0000;
                end
            endcase
            do_cycle("rand", a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     (a == MMIO_BASE + 8 && $urandom_range(0, 7) != 0) ? 32'h0 : $urandom,
                     $urandom_range(0, 9) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
